// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: CDB owner codes, default unit latencies and the mod-3 round-robin step shared by the issue arbiter
package issue_unit_pkg;
  typedef enum logic [1:0] {
    CDB_NONE = 2'd0,
    CDB_INT  = 2'd1,
    CDB_MUL  = 2'd2,
    CDB_DIV  = 2'd3
  } cdb_own_e;
  localparam int DEF_INT_LAT = 1;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 7;
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
endpackage

// File: rtl/issue_unit_if.sv
// issue_unit_if: issue-queue handshake bus (ready in, done/div_busy/cdb_sel out); master = queues, slave = issue_unit
interface issue_unit_if;
  import issue_unit_pkg::*;
  logic     issueint_ready;
  logic     issuemul_ready;
  logic     issuediv_ready;
  logic     issueint_done;
  logic     issuemul_done;
  logic     issuediv_done;
  logic     div_busy;
  cdb_own_e cdb_sel;
  modport master (
    output issueint_ready, issuemul_ready, issuediv_ready,
    input  issueint_done, issuemul_done, issuediv_done, div_busy, cdb_sel
  );
  modport slave (
    input  issueint_ready, issuemul_ready, issuediv_ready,
    output issueint_done, issuemul_done, issuediv_done, div_busy, cdb_sel
  );
endinterface

// File: rtl/issue_unit_cdb_slot_tracker.sv
// cdb_slot_tracker: CDB claim/owner calendar (in clk, reset, gnt; out int/mul/div_claimed for each unit's landing slot, registered cdb_sel)
module cdb_slot_tracker
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT = DEF_INT_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic     clk,
  input  logic     reset,
  input  cdb_own_e gnt,
  output logic     int_claimed,
  output logic     mul_claimed,
  output logic     div_claimed,
  output cdb_own_e cdb_sel
);
  logic [DIV_LAT:0]      res_q, res_d;
  logic [DIV_LAT:0][1:0] own_q, own_d;
  always_comb begin
    res_d = res_q >> 1;
    own_d = {CDB_NONE, own_q[DIV_LAT:1]};
    if (gnt == CDB_INT) begin
      res_d[INT_LAT-1] = 1'b1;
      own_d[INT_LAT-1] = CDB_INT;
    end
    if (gnt == CDB_MUL) begin
      res_d[MUL_LAT-1] = 1'b1;
      own_d[MUL_LAT-1] = CDB_MUL;
    end
    if (gnt == CDB_DIV) begin
      res_d[DIV_LAT-1] = 1'b1;
      own_d[DIV_LAT-1] = CDB_DIV;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      own_q <= '0;
    end else begin
      res_q <= res_d;
      own_q <= own_d;
    end
  end
  assign int_claimed = res_q[INT_LAT];
  assign mul_claimed = res_q[MUL_LAT];
  assign div_claimed = res_q[DIV_LAT];
  assign cdb_sel     = cdb_own_e'(own_q[0]);
endmodule

// File: rtl/issue_unit.sv
// issue_unit: round-robin int/mul/div issue arbiter gated by CDB slot claims (in clk, reset, bus.*_ready; out bus.*_done, bus.div_busy, bus.cdb_sel)
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT = DEF_INT_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input logic         clk,
  input logic         reset,
  issue_unit_if.slave bus
);
  localparam int CW = $clog2(DIV_LAT);
  logic [1:0]    rr_q, rr_d, rr_1, rr_2, gnt_idx;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    elig;
  logic          int_claimed, mul_claimed, div_claimed, gnt_any;
  cdb_own_e      gnt;
  always_comb begin
    elig = {bus.issuediv_ready & (div_cnt_q == '0) & ~div_claimed,
            bus.issuemul_ready & ~mul_claimed,
            bus.issueint_ready & ~int_claimed} & {3{~reset}};
    rr_1 = rr_next(rr_q);
    rr_2 = rr_next(rr_1);
    gnt_idx = elig[rr_q] ? rr_q : elig[rr_1] ? rr_1 : rr_2;
    gnt_any = |elig;
    gnt = gnt_any ? cdb_own_e'(gnt_idx + 2'd1) : CDB_NONE;
    rr_d = gnt_any ? rr_next(gnt_idx) : rr_q;
    div_cnt_d = (gnt == CDB_DIV) ? CW'(DIV_LAT - 1) :
                (div_cnt_q != '0) ? div_cnt_q - CW'(1) : div_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      div_cnt_q <= '0;
    end else begin
      rr_q      <= rr_d;
      div_cnt_q <= div_cnt_d;
    end
  end
  cdb_slot_tracker #(
    .INT_LAT(INT_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .gnt        (gnt),
    .int_claimed(int_claimed),
    .mul_claimed(mul_claimed),
    .div_claimed(div_claimed),
    .cdb_sel    (bus.cdb_sel)
  );
  assign bus.issueint_done = (gnt == CDB_INT);
  assign bus.issuemul_done = (gnt == CDB_MUL);
  assign bus.issuediv_done = (gnt == CDB_DIV);
  assign bus.div_busy      = (div_cnt_q != '0);
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed scenarios plus randomized traffic checked against a CDB-calendar reference model
module tb_issue_unit;
  import issue_unit_pkg::*;
  localparam int IL = DEF_INT_LAT;
  localparam int ML = DEF_MUL_LAT;
  localparam int DL = DEF_DIV_LAT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int sched[int];
  int m_cyc, m_rr, m_last_div;
  logic [2:0] ed, ad;
  logic [1:0] ec, ac;
  logic eb, ab;
  issue_unit_if bus();
  issue_unit #(.INT_LAT(IL), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    sched.delete();
    m_cyc = 0;
    m_rr = 0;
    m_last_div = -1000;
  endtask
  task automatic cyc(input logic rst_v, input logic [2:0] rdy);
    int lat[3];
    logic ok[3];
    int u;
    lat[0] = IL;
    lat[1] = ML;
    lat[2] = DL;
    reset = rst_v;
    bus.issueint_ready = rdy[0];
    bus.issuemul_ready = rdy[1];
    bus.issuediv_ready = rdy[2];
    @(negedge clk);
    ad = {bus.issuediv_done, bus.issuemul_done, bus.issueint_done};
    ac = bus.cdb_sel;
    ab = bus.div_busy;
    ed = '0;
    ec = '0;
    eb = 1'b0;
    if (rst_v) model_reset();
    else begin
      eb = (m_cyc > m_last_div) && (m_cyc < m_last_div + DL);
      ec = sched.exists(m_cyc) ? 2'(sched[m_cyc]) : 2'd0;
      ok[0] = rdy[0] && !sched.exists(m_cyc + IL);
      ok[1] = rdy[1] && !sched.exists(m_cyc + ML);
      ok[2] = rdy[2] && !eb && !sched.exists(m_cyc + DL);
      for (int i = 0; i < 3; i++) begin
        u = (m_rr + i) % 3;
        if (ok[u]) begin
          ed[u] = 1'b1;
          sched[m_cyc + lat[u]] = u + 1;
          m_rr = (u + 1) % 3;
          if (u == 2) m_last_div = m_cyc;
          break;
        end
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    cyc(1'b1, 3'b000);
    cyc(1'b1, 3'b000);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 3'b111);
      n_chk++; if (ad !== 3'b000) $display("FAIL reset_done: got %b want 000", ad); else n_pass++;
      n_chk++; if (ac !== 2'b00) $display("FAIL reset_cdb: got %b want 00", ac); else n_pass++;
      n_chk++; if (ab !== 1'b0) $display("FAIL reset_busy: got %b want 0", ab); else n_pass++;
    end
    cyc(1'b0, 3'b111);
    n_chk++; if (ad !== 3'b001) $display("FAIL release_done: got %b want 001", ad); else n_pass++;
  endtask
  task automatic test_int_stream();
    do_reset();
    for (int t = 0; t < 7; t++) begin
      cyc(1'b0, (t < 5) ? 3'b001 : 3'b000);
      n_chk++; if (ad !== ((t < 5) ? 3'b001 : 3'b000)) $display("FAIL int_stream_done t%0d: got %b", t, ad); else n_pass++;
      n_chk++; if (ac !== ((t >= 1 && t <= 5) ? 2'b01 : 2'b00)) $display("FAIL int_stream_cdb t%0d: got %b", t, ac); else n_pass++;
    end
  endtask
  task automatic test_slot_conflict();
    logic [2:0] rdy[6];
    rdy = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
    do_reset();
    for (int t = 0; t < 6; t++) begin
      cyc(1'b0, rdy[t]);
      if (t == 0) begin n_chk++; if (ad !== 3'b010) $display("FAIL conflict_mul t0: got %b want 010", ad); else n_pass++; end
      if (t == 3) begin n_chk++; if (ad !== 3'b000) $display("FAIL conflict_block t3: got %b want 000", ad); else n_pass++; end
      if (t == 4) begin n_chk++; if (ad !== 3'b001) $display("FAIL conflict_retry t4: got %b want 001", ad); else n_pass++; end
      if (t == 4) begin n_chk++; if (ac !== 2'b10) $display("FAIL conflict_cdb t4: got %b want 10", ac); else n_pass++; end
      if (t == 5) begin n_chk++; if (ac !== 2'b01) $display("FAIL conflict_cdb t5: got %b want 01", ac); else n_pass++; end
    end
  endtask
  task automatic test_round_robin();
    logic [2:0] eg[4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int t = 0; t < 10; t++) begin
      cyc(1'b0, 3'b111);
      if (t < 4) begin n_chk++; if (ad !== eg[t]) $display("FAIL rr_grant t%0d: got %b want %b", t, ad, eg[t]); else n_pass++; end
      if (t == 1 || t == 4) begin n_chk++; if (ac !== 2'b01) $display("FAIL rr_cdb t%0d: got %b want 01", t, ac); else n_pass++; end
      if (t == 5) begin n_chk++; if (ac !== 2'b10) $display("FAIL rr_cdb t5: got %b want 10", ac); else n_pass++; end
      if (t == 9) begin n_chk++; if (ac !== 2'b11) $display("FAIL rr_cdb t9: got %b want 11", ac); else n_pass++; end
    end
  endtask
  task automatic test_div_busy();
    do_reset();
    for (int t = 0; t < 15; t++) begin
      cyc(1'b0, 3'b100);
      n_chk++; if (ad !== ((t % 7 == 0) ? 3'b100 : 3'b000)) $display("FAIL div_done t%0d: got %b", t, ad); else n_pass++;
      n_chk++; if (ab !== ((t % 7 != 0) ? 1'b1 : 1'b0)) $display("FAIL div_busy t%0d: got %b", t, ab); else n_pass++;
      n_chk++; if (ac !== ((t == 7 || t == 14) ? 2'b11 : 2'b00)) $display("FAIL div_cdb t%0d: got %b", t, ac); else n_pass++;
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    cyc(1'b0, 3'b010);
    n_chk++; if (ad !== 3'b010) $display("FAIL midrst_mul: got %b want 010", ad); else n_pass++;
    cyc(1'b0, 3'b000);
    cyc(1'b1, 3'b111);
    n_chk++; if (ad !== 3'b000) $display("FAIL midrst_done: got %b want 000", ad); else n_pass++;
    n_chk++; if (ac !== 2'b00) $display("FAIL midrst_cdb: got %b want 00", ac); else n_pass++;
    cyc(1'b0, 3'b000);
    cyc(1'b0, 3'b000);
    n_chk++; if (ac !== 2'b00) $display("FAIL midrst_cdb_t4: got %b want 00", ac); else n_pass++;
    cyc(1'b0, 3'b111);
    n_chk++; if (ad !== 3'b001) $display("FAIL midrst_rr: got %b want 001", ad); else n_pass++;
  endtask
  task automatic test_random();
    logic r;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      r = ($urandom_range(0, 79) == 0);
      cyc(r, 3'($urandom));
      n_chk++; if (ad !== ed) $display("FAIL rand_done cyc%0d: got %b want %b", t, ad, ed); else n_pass++;
      n_chk++; if (ac !== ec) $display("FAIL rand_cdb cyc%0d: got %b want %b", t, ac, ec); else n_pass++;
      n_chk++; if (ab !== eb) $display("FAIL rand_busy cyc%0d: got %b want %b", t, ab, eb); else n_pass++;
    end
  endtask
  initial begin
    bus.issueint_ready = 1'b0;
    bus.issuemul_ready = 1'b0;
    bus.issuediv_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_int_stream();
    test_slot_conflict();
    test_round_robin();
    test_div_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
# issue_unit

Central issue arbiter for the Tomasulo back end. Each cycle it grants at most one of the integer, multiply and divide issue queues. A grant is made only when the CDB slot that the result will occupy is free. It also tracks which unit owns the CDB in each cycle and drives the CDB source select. It sits directly downstream of the integer issue queue, which presents `issueint_*` and samples `issueint_done` at the next posedge.

## Interface
- `INT_LAT`, default 1: cycles from integer grant to result on CDB.
- `MUL_LAT`, default 4: cycles from multiply grant to CDB; multiplier is fully pipelined.
- `DIV_LAT`, default 7: cycles from divide grant to CDB; divider is non-pipelined. Legal values: 1 <= INT_LAT < MUL_LAT < DIV_LAT.
- `clk`  in  1: single clock; all state on posedge.
- `reset`  in  1: asynchronous, active-high.
- `issueint_ready`  in  1: integer queue holds a ready instruction.
- `issuemul_ready`  in  1: multiply queue holds a ready instruction.
- `issuediv_ready`  in  1: divide queue holds a ready instruction.
- `issueint_done`  out  1: integer grant this cycle (combinational).
- `issuemul_done`  out  1: multiply grant this cycle (combinational).
- `issuediv_done`  out  1: divide grant this cycle (combinational).
- `div_busy`  out  1: divider occupied; a divide may not be granted.
- `cdb_sel`  out  2: CDB owner this cycle. 00 none, 01 int, 10 mul, 11 div.

## Operation
- **State**
  - `res_r[0:DIV_LAT]`: CDB claim bits. Bit k set means the CDB in cycle t+k is already claimed.
  - `own_r[0:DIV_LAT]`: 2-bit owner code per slot.
  - `rr_r`: round-robin pointer (0 int, 1 mul, 2 div).
  - `div_cnt_r`: divider countdown.
- **Eligibility**
  - int: `issueint_ready & ~res_r[INT_LAT]`.
  - mul: `issuemul_ready & ~res_r[MUL_LAT]`.
  - div: `issuediv_ready & ~div_busy & ~res_r[DIV_LAT]`.
- **Arbitration**
  - Search eligible units in order rr_r, rr_r+1, rr_r+2 (mod 3). The first eligible unit is granted.
  - At most one done output is high per cycle.
  - On a grant, `rr_r <= (granted+1) mod 3`. With no grant, rr_r holds.
- **Slot update each cycle**
  - `res_next[k] = res_r[k+1]` and `own_next[k] = own_r[k+1]` for k < DIV_LAT.
  - `res_next[DIV_LAT] = 0` and `own_next[DIV_LAT] = 00`.
  - Then, on a grant with latency L, set `res_next[L-1] = 1` and `own_next[L-1] = code`. No collision is possible because eligibility checked `res_r[L]`.
- **Outputs**
  - `cdb_sel = own_r[0]`, registered.
  - `div_busy = (div_cnt_r != 0)`.
  - A divide grant loads `div_cnt_r` with DIV_LAT-1; otherwise it decrements while nonzero.
- **Reset**
  - All res/own bits 0, rr_r = 0, div_cnt_r = 0.
  - While reset is high, all done outputs are forced to 0, `cdb_sel` = 00 and `div_busy` = 0.
  - Reset mid-operation discards every pending claim immediately. Units must be flushed by the same reset.

## Timing
- A grant in cycle t produces `cdb_sel` = unit code in cycle t+L, for exactly one cycle.
- Done signals are combinational from ready and state, with zero latency. The queue sees done in the same cycle and shifts at the next posedge.
- After a divide grant at t, `div_busy` is 1 for cycles t+1 through t+DIV_LAT-1. The next divide grant can occur no earlier than t+DIV_LAT.
- An int request in cycle t is blocked when a mul or div granted earlier lands in slot t+INT_LAT. It retries the next cycle.
- Sustained mul or div traffic cannot starve int: round-robin guarantees int a grant within 3 eligible cycles.

## Structure
- The shared package holds:
  - owner codes `CDB_NONE`, `CDB_INT`, `CDB_MUL`, `CDB_DIV`;
  - default latency constants.
- One sub-module, `cdb_slot_tracker`, owns `res_r`, `own_r`, the shift/claim logic and the `cdb_sel` output.
- Arbitration, the round-robin pointer and the divide counter stay in `issue_unit`.

## Test plan
- **Reset:** reset=1 with all readies high -> all done = 0, `cdb_sel` = 00, `div_busy` = 0. Release at t0 -> `issueint_done` = 1 at t0.
- **Int stream:** only `issueint_ready` = 1 for 5 cycles from t0 -> `issueint_done` = 1 at t0..t4, `cdb_sel` = 01 at t1..t5, 00 at t6.
- **Slot conflict:** mul granted at t0 (int not ready) and `issueint_ready` rises at t3 -> `issueint_done` = 0 at t3, 1 at t4. `cdb_sel` = 10 at t4, 01 at t5.
- **Round robin:** all readies high from t0 after reset -> grants int t0, mul t1, div t2, int t3. `cdb_sel` = 01 at t1 and t4, 10 at t5, 11 at t9.
- **Divider busy:** only `issuediv_ready` = 1 continuously from t0 -> `issuediv_done` = 1 at t0 and t7 only. `div_busy` = 1 at t1..t6. `cdb_sel` = 11 at t7 and t14.
- **Reset mid-op:** mul granted at t0, reset pulsed at t2 -> `cdb_sel` = 00 immediately and stays 00 at t4. rr_r = 0, so int wins first after release when all readies are high.
